// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one registered ALU between two requesters, results returned tagged
//   CLK/RST_N                  clock, async active-low reset
//   REQn/OP1_n/OP2_n/OPR_n     requester n operation, held until GNTn
//   GNTn                       combinational accept for requester n
//   ALU_OPERAND1/2/OPERATOR    registered issue stage into the ALU
//   ALU_RESULT                 ALU output, trusted only when the wait stage is valid
//   RSP_VALIDn/RSP_DATA        one-cycle result pulse per requester, shared data
//   BUSY                       issue or wait stage occupied
module alu_arbiter #(
  parameter int WORD_LEN = 32,
  parameter int OPERATOR_LEN = 4,
  parameter logic [OPERATOR_LEN-1:0] NOP_CODE = '0
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    REQ0,
  input  logic [WORD_LEN-1:0]     OP1_0,
  input  logic [WORD_LEN-1:0]     OP2_0,
  input  logic [OPERATOR_LEN-1:0] OPR_0,
  output logic                    GNT0,
  input  logic                    REQ1,
  input  logic [WORD_LEN-1:0]     OP1_1,
  input  logic [WORD_LEN-1:0]     OP2_1,
  input  logic [OPERATOR_LEN-1:0] OPR_1,
  output logic                    GNT1,
  output logic [WORD_LEN-1:0]     ALU_OPERAND1,
  output logic [WORD_LEN-1:0]     ALU_OPERAND2,
  output logic [OPERATOR_LEN-1:0] ALU_OPERATOR,
  input  logic [WORD_LEN-1:0]     ALU_RESULT,
  output logic                    RSP_VALID0,
  output logic                    RSP_VALID1,
  output logic [WORD_LEN-1:0]     RSP_DATA,
  output logic                    BUSY
);
  logic                    w_gnt0, w_gnt1;
  logic                    r_ptr, r_issue_v, r_issue_id, r_wait_v, r_wait_id, r_rsp_v0, r_rsp_v1;
  logic [WORD_LEN-1:0]     r_op1, r_op2, r_rsp_data;
  logic [OPERATOR_LEN-1:0] r_opr;
  // r_ptr names the port favoured on contention; gating with RST_N keeps grants low in reset
  always_comb begin
    w_gnt0 = RST_N & REQ0 & (~REQ1 | ~r_ptr);
    w_gnt1 = RST_N & REQ1 & (~REQ0 | r_ptr);
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ptr      <= 1'b0;
      r_issue_v  <= 1'b0;
      r_issue_id <= 1'b0;
      r_op1      <= '0;
      r_op2      <= '0;
      r_opr      <= NOP_CODE;
      r_wait_v   <= 1'b0;
      r_wait_id  <= 1'b0;
      r_rsp_v0   <= 1'b0;
      r_rsp_v1   <= 1'b0;
      r_rsp_data <= '0;
    end else begin
      r_ptr      <= w_gnt0 ? 1'b1 : w_gnt1 ? 1'b0 : r_ptr;
      r_issue_v  <= w_gnt0 | w_gnt1;
      r_issue_id <= w_gnt1;
      r_op1      <= w_gnt0 ? OP1_0 : w_gnt1 ? OP1_1 : '0;
      r_op2      <= w_gnt0 ? OP2_0 : w_gnt1 ? OP2_1 : '0;
      r_opr      <= w_gnt0 ? OPR_0 : w_gnt1 ? OPR_1 : NOP_CODE;
      r_wait_v   <= r_issue_v;
      r_wait_id  <= r_issue_id;
      r_rsp_v0   <= r_wait_v & ~r_wait_id;
      r_rsp_v1   <= r_wait_v & r_wait_id;
      if (r_wait_v) r_rsp_data <= ALU_RESULT;
    end
  end
  assign GNT0         = w_gnt0;
  assign GNT1         = w_gnt1;
  assign ALU_OPERAND1 = r_op1;
  assign ALU_OPERAND2 = r_op2;
  assign ALU_OPERATOR = r_opr;
  assign RSP_VALID0   = r_rsp_v0;
  assign RSP_VALID1   = r_rsp_v1;
  assign RSP_DATA     = r_rsp_data;
  assign BUSY         = r_issue_v | r_wait_v;
endmodule
